window_generator: RTL
=====================

WINDOW_GENERATOR -- requirements
Module: window_generator

Interface
REQ-001 SHALL have parameter EXP_WIDTH, default 5, fp exponent bits.
REQ-002 SHALL have parameter FRAC_WIDTH, default 10, fp fraction bits; FP_WIDTH_REG = 1+EXP_WIDTH+FRAC_WIDTH (derived, 16).
REQ-003 SHALL have parameters WINDOW_WIDTH and WINDOW_HEIGHT, default 5 each, window size; both odd, >=3.
REQ-004 SHALL have parameters IMAGE_WIDTH, default 640, and IMAGE_HEIGHT, default 480, frame size; IMAGE_WIDTH >= WINDOW_WIDTH.
REQ-005 SHALL have port clk_i, input, 1, the single clock.
REQ-006 SHALL have port rst_i, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port data_i, input, FP_WIDTH_REG, raster-order pixel, treated as opaque bits.
REQ-008 SHALL have ports col_i and row_i, input, 16 each, coordinate of data_i.
REQ-009 SHALL have port valid_i, input, 1, data_i/col_i/row_i qualifier; no backpressure.
REQ-010 SHALL have port window_o, output, FP_WIDTH_REG x [WINDOW_HEIGHT][WINDOW_WIDTH], [0][0] = top-left (oldest row, oldest column).
REQ-011 SHALL have ports col_o and row_o, output, 16 each, centre coordinate of window_o.
REQ-012 SHALL have port valid_o, output, 1, window_o/col_o/row_o qualifier.

Function
REQ-013 SHALL hold WINDOW_HEIGHT-1 cascaded line buffers of IMAGE_WIDTH entries; on accepted input at column c: lb[0][c]<=data_i, lb[k][c]<=lb[k-1][c] (read-before-write).
REQ-014 SHALL, on accepted input, form new column v[H-1]=data_i, v[H-1-k]=lb[k-1][c] for k=1..H-1, shift window left one column (window[y][x]<=window[y][x+1]), load v into column W-1.
REQ-015 SHALL accept input only when valid_i=1 and col_i<IMAGE_WIDTH and row_i<IMAGE_HEIGHT; otherwise line buffers, window, and counters are unchanged.
REQ-016 SHALL keep rows_filled counter (0..H-1, saturating): cleared on accepted (col_i=0,row_i=0); incremented on accepted col_i=IMAGE_WIDTH-1 otherwise.
REQ-017 SHALL assert valid_o exactly one cycle after an accepted input with col_i>=W-1, row_i>=H-1, rows_filled=H-1; else valid_o=0 that cycle.
REQ-018 SHALL drive col_o=col_i-(W-1)/2, row_o=row_i-(H-1)/2 of that input, registered with the same 1-cycle latency.
REQ-019 SHALL leave window_o, col_o, row_o holding last values when valid_o=0.
REQ-020 SHALL emit exactly (IMAGE_WIDTH-W+1)*(IMAGE_HEIGHT-H+1) windows per complete frame; no border padding.
REQ-021 SHALL sustain one accepted input per cycle; gaps in valid_i change nothing but timing.

Reset
REQ-022 SHALL, while rst_i=0, force valid_o=0, col_o=0, row_o=0, window_o all zero, rows_filled=0, asynchronously.
REQ-023 SHALL NOT reset line-buffer contents; stale data is masked by rows_filled.
REQ-024 SHALL, after mid-frame reset, emit no window until a new frame start (0,0) and H-1 complete rows.

Structure
REQ-025 SHALL need no new package; FP_WIDTH_REG derived locally as in the convolution blocks downstream.
REQ-026 SHALL instantiate sub-module line_buffer (IMAGE_WIDTH x FP_WIDTH_REG RAM, one read + one write per cycle same address, read returns old data), WINDOW_HEIGHT-1 instances.
REQ-027 SHALL connect window_o/col_o/row_o/valid_o directly to window_i/col_i/row_i/valid_i of the fp convolution wrappers.

Verification (IMAGE_WIDTH=8, IMAGE_HEIGHT=6, data_i = row*16+col)
REQ-028 SHALL cover full frame, valid_i every cycle -> 8 valid_o pulses; first: col_o=2,row_o=2, window_o[0][0]=0x0000, [2][2]=0x0022, [4][4]=0x0044; last: col_o=5,row_o=3, [4][4]=0x0057.
REQ-029 SHALL cover valid_i on alternate cycles -> identical 8 windows, each valid_o exactly 1 cycle after its qualifying valid_i.
REQ-030 SHALL cover rst_i low at row 3 col 5, then resume -> no valid_o rest of frame; next frame yields all 8 correct windows.
REQ-031 SHALL cover valid_i with col_i=8 or row_i=6, data 0xFFFF -> ignored, no 0xFFFF in any later window, valid_o stays 0.
REQ-032 SHALL cover two back-to-back frames, second data = first+0x0100 -> second frame windows contain only 0x01xx values.

Source files
------------

// File: rtl/window_generator_line_buffer.sv
// One image row of pixel storage: single address shared by read and write,
// so the read port returns the value written one line earlier.
module line_buffer #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 16,
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Row storage write; contents are intentionally left unreset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_r[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_r[addr_i];

endmodule

// File: rtl/window_generator.sv
// Sliding WINDOW_HEIGHT x WINDOW_WIDTH neighbourhood generator over a raster
// pixel stream, feeding the fp convolution wrappers.
module window_generator #(
  parameter int EXP_WIDTH     = 5,
  parameter int FRAC_WIDTH    = 10,
  parameter int WINDOW_WIDTH  = 5,
  parameter int WINDOW_HEIGHT = 5,
  parameter int IMAGE_WIDTH   = 640,
  parameter int IMAGE_HEIGHT  = 480,
  localparam int FP_WIDTH_REG = 1 + EXP_WIDTH + FRAC_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [FP_WIDTH_REG-1:0] data_i,
  input  logic [15:0]             col_i,
  input  logic [15:0]             row_i,
  input  logic                    valid_i,
  output logic [WINDOW_HEIGHT-1:0][WINDOW_WIDTH-1:0][FP_WIDTH_REG-1:0] window_o,
  output logic [15:0]             col_o,
  output logic [15:0]             row_o,
  output logic                    valid_o
);

  localparam int ADDR_W = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam int RF_W   = $clog2(WINDOW_HEIGHT);
  localparam int HALF_W = (WINDOW_WIDTH - 1) / 2;
  localparam int HALF_H = (WINDOW_HEIGHT - 1) / 2;

  typedef logic [FP_WIDTH_REG-1:0] pix_t;
  typedef logic [WINDOW_HEIGHT-1:0][WINDOW_WIDTH-1:0][FP_WIDTH_REG-1:0] win_t;

  logic                         accept_s;
  logic                         emit_s;
  logic [ADDR_W-1:0]            addr_s;
  pix_t                         lb_rd_s [WINDOW_HEIGHT-1];
  pix_t                         lb_wr_s [WINDOW_HEIGHT-1];
  logic [WINDOW_HEIGHT-1:0][FP_WIDTH_REG-1:0] col_new_s;
  win_t                         win_next_s;
  win_t                         win_r;
  win_t                         window_o_r;
  logic [15:0]                  col_o_r;
  logic [15:0]                  row_o_r;
  logic                         valid_o_r;
  logic [RF_W-1:0]              rows_filled_r;

  assign accept_s = valid_i && (col_i < 16'(IMAGE_WIDTH)) && (row_i < 16'(IMAGE_HEIGHT));

  // rows_filled masks stale line-buffer data left over from a previous frame or reset.
  assign emit_s = accept_s
               && (col_i >= 16'(WINDOW_WIDTH - 1))
               && (row_i >= 16'(WINDOW_HEIGHT - 1))
               && (rows_filled_r == RF_W'(WINDOW_HEIGHT - 1));

  assign addr_s = col_i[ADDR_W-1:0];

  for (genvar k = 0; k < WINDOW_HEIGHT - 1; k++) begin : g_lb
    if (k == 0) begin : g_first
      assign lb_wr_s[k] = data_i;
    end else begin : g_cascade
      assign lb_wr_s[k] = lb_rd_s[k-1];
    end

    line_buffer #(
      .DEPTH (IMAGE_WIDTH),
      .WIDTH (FP_WIDTH_REG)
    ) u_line_buffer (
      .clk_i   (clk_i),
      .we_i    (accept_s),
      .addr_i  (addr_s),
      .wdata_i (lb_wr_s[k]),
      .rdata_o (lb_rd_s[k])
    );
  end

  // Incoming column: oldest row at index 0, the live pixel at the bottom.
  always_comb begin
    col_new_s = '0;
    col_new_s[WINDOW_HEIGHT-1] = data_i;
    for (int k = 1; k < WINDOW_HEIGHT; k++) begin
      col_new_s[WINDOW_HEIGHT-1-k] = lb_rd_s[k-1];
    end
  end

  // Shift the window one column left and append the incoming column.
  always_comb begin
    win_next_s = win_r;
    if (accept_s) begin
      for (int y = 0; y < WINDOW_HEIGHT; y++) begin
        for (int x = 0; x < WINDOW_WIDTH - 1; x++) begin
          win_next_s[y][x] = win_r[y][x+1];
        end
        win_next_s[y][WINDOW_WIDTH-1] = col_new_s[y];
      end
    end else begin
      win_next_s = win_r;
    end
  end

  // Window shift register and registered outputs; outputs hold between windows.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      win_r      <= '0;
      window_o_r <= '0;
      col_o_r    <= 16'd0;
      row_o_r    <= 16'd0;
      valid_o_r  <= 1'b0;
    end else begin
      win_r     <= win_next_s;
      valid_o_r <= emit_s;
      if (emit_s) begin
        window_o_r <= win_next_s;
        col_o_r    <= col_i - 16'(HALF_W);
        row_o_r    <= row_i - 16'(HALF_H);
      end
    end
  end

  // Count completed rows since frame start, saturating at WINDOW_HEIGHT-1.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rows_filled_r <= '0;
    end else if (accept_s) begin
      if ((col_i == 16'd0) && (row_i == 16'd0)) begin
        rows_filled_r <= '0;
      end else if ((col_i == 16'(IMAGE_WIDTH - 1))
                   && (rows_filled_r != RF_W'(WINDOW_HEIGHT - 1))) begin
        rows_filled_r <= rows_filled_r + RF_W'(1);
      end
    end
  end

  assign window_o = window_o_r;
  assign col_o    = col_o_r;
  assign row_o    = row_o_r;
  assign valid_o  = valid_o_r;

endmodule
